// File: rtl/hdu_pkg.sv
// Shared types and control-word constants for the hazard detection / pipeline-control unit.
package hdu_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LD_STALL = 2'd1,
        MEM_WAIT = 2'd2
    } hdu_state_e;

    typedef struct packed {
        logic ifid_clear;
        logic idex_clear;
        logic exmem_clear;
        logic ifid_wren;
        logic idex_wren;
        logic exmem_wren;
        logic pc_wren;
    } hdu_ctrl_t;

    // Bit order: {ifid/idex/exmem clear, ifid/idex/exmem wren, pc_wren}
    localparam hdu_ctrl_t CTRL_DEFAULT = 7'b000_111_1;
    localparam hdu_ctrl_t CTRL_FLUSH   = 7'b111_111_1;
    localparam hdu_ctrl_t CTRL_FREEZE  = 7'b000_000_0;
    localparam hdu_ctrl_t CTRL_STALL   = 7'b010_011_0;

endpackage

// File: rtl/hdu_fwd_ctrl_if.sv
// Pipeline-side signal bundle of the HDU: stage status in, register clear/write-enables out.
interface hdu_fwd_ctrl_if #(parameter int REG_AW = 5);
    logic              EXMEM_pcsel;
    logic              EXMEM_is_br;
    logic              EXMEM_is_uncbr;
    logic              EXMEM_memop;
    logic              MEM_ack;
    logic              IDEX_rdwren;
    logic              IDEX_is_load;
    logic [REG_AW-1:0] IDEX_rd;
    logic              EXMEM_rdwren;
    logic [REG_AW-1:0] EXMEM_rd;
    logic [REG_AW-1:0] IFID_rs1;
    logic [REG_AW-1:0] IFID_rs2;
    logic              IFID_rs1_used;
    logic              IFID_rs2_used;
    logic              IFID_clear;
    logic              IDEX_clear;
    logic              EXMEM_clear;
    logic              IFID_wren;
    logic              IDEX_wren;
    logic              EXMEM_wren;
    logic              pc_wren;

    modport slave (
        input  EXMEM_pcsel, EXMEM_is_br, EXMEM_is_uncbr, EXMEM_memop, MEM_ack,
               IDEX_rdwren, IDEX_is_load, IDEX_rd, EXMEM_rdwren, EXMEM_rd,
               IFID_rs1, IFID_rs2, IFID_rs1_used, IFID_rs2_used,
        output IFID_clear, IDEX_clear, EXMEM_clear, IFID_wren, IDEX_wren, EXMEM_wren, pc_wren
    );

    modport master (
        output EXMEM_pcsel, EXMEM_is_br, EXMEM_is_uncbr, EXMEM_memop, MEM_ack,
               IDEX_rdwren, IDEX_is_load, IDEX_rd, EXMEM_rdwren, EXMEM_rd,
               IFID_rs1, IFID_rs2, IFID_rs1_used, IFID_rs2_used,
        input  IFID_clear, IDEX_clear, EXMEM_clear, IFID_wren, IDEX_wren, EXMEM_wren, pc_wren
    );
endinterface

// File: rtl/hdu_src_match.sv
// RAW comparator of the IF/ID source registers against one later stage's destination.
// Purely combinational; x0 never matches.
module hdu_src_match #(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] rs1,
    input  logic [REG_AW-1:0] rs2,
    input  logic              rs1_used,
    input  logic              rs2_used,
    input  logic [REG_AW-1:0] rd,
    input  logic              rdwren,
    output logic              hit
);
    logic hit1;
    logic hit2;

    assign hit1 = rs1_used && (rs1 != '0) && (rs1 == rd);
    assign hit2 = rs2_used && (rs2 != '0) && (rs2 == rd);
    assign hit  = rdwren && (hit1 || hit2);
endmodule

// File: rtl/hdu_fwd_ctrl.sv
// Hazard detection and pipeline control: flush > memory freeze > RAW/load-use stall > run.
// Control outputs are combinational in the current cycle; counters and timeout are registered.
module hdu_fwd_ctrl
    import hdu_pkg::*;
#(
    parameter int REG_AW      = 5,
    parameter int FWD_EN      = 1,
    parameter int LOAD_LAT    = 1,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    hdu_fwd_ctrl_if.slave    pif,
    output logic             o_mem_timeout,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_flush_cnt
);
    localparam int                WAIT_W   = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);
    localparam logic [2:0]        LD_INIT  = 3'(LOAD_LAT - 1);

    hdu_state_e        state_q, state_d, ret_q, ret_d, eff_state;
    logic [2:0]        ld_cnt_q, ld_cnt_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              tmo_q, tmo_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
    hdu_ctrl_t         ctrl_c, ctrl;
    logic              idex_hit, exmem_hit, flush, freeze;

    hdu_src_match #(.REG_AW(REG_AW)) u_match_idex (
        .rs1(pif.IFID_rs1), .rs2(pif.IFID_rs2),
        .rs1_used(pif.IFID_rs1_used), .rs2_used(pif.IFID_rs2_used),
        .rd(pif.IDEX_rd), .rdwren(pif.IDEX_rdwren), .hit(idex_hit)
    );

    hdu_src_match #(.REG_AW(REG_AW)) u_match_exmem (
        .rs1(pif.IFID_rs1), .rs2(pif.IFID_rs2),
        .rs1_used(pif.IFID_rs1_used), .rs2_used(pif.IFID_rs2_used),
        .rd(pif.EXMEM_rd), .rdwren(pif.EXMEM_rdwren), .hit(exmem_hit)
    );

    assign flush  = pif.EXMEM_pcsel && (pif.EXMEM_is_br || pif.EXMEM_is_uncbr);
    assign freeze = pif.EXMEM_memop && !pif.MEM_ack;
    // While waiting on memory, decisions are made as if still in the state we froze from.
    assign eff_state = (state_q == MEM_WAIT) ? ret_q : state_q;

    always_comb begin
        ctrl_c     = CTRL_DEFAULT;
        state_d    = eff_state;
        ret_d      = ret_q;
        ld_cnt_d   = ld_cnt_q;
        wait_cnt_d = '0;
        if (flush) begin
            ctrl_c   = CTRL_FLUSH;
            state_d  = RUN;
            ld_cnt_d = '0;
        end else if (freeze) begin
            ctrl_c     = CTRL_FREEZE;
            state_d    = MEM_WAIT;
            ret_d      = eff_state;
            wait_cnt_d = (wait_cnt_q == WAIT_MAX) ? WAIT_MAX : wait_cnt_q + WAIT_W'(1);
        end else if (FWD_EN == 0) begin
            if (idex_hit || exmem_hit) begin
                ctrl_c = CTRL_STALL;
            end
        end else if (eff_state == LD_STALL) begin
            ctrl_c   = CTRL_STALL;
            ld_cnt_d = (ld_cnt_q == 3'd0) ? 3'd0 : ld_cnt_q - 3'd1;
            if (ld_cnt_q <= 3'd1) begin
                state_d = RUN;
            end
        end else if (idex_hit && pif.IDEX_is_load) begin
            ctrl_c = CTRL_STALL;
            if (LOAD_LAT > 1) begin
                ld_cnt_d = LD_INIT;
                state_d  = LD_STALL;
            end
        end
    end

    always_comb begin
        ctrl        = i_rst_n ? ctrl_c : CTRL_DEFAULT;
        tmo_d       = tmo_q || (wait_cnt_q == WAIT_MAX);
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!ctrl.pc_wren && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (flush && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= RUN;
            ret_q       <= RUN;
            ld_cnt_q    <= '0;
            wait_cnt_q  <= '0;
            tmo_q       <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            ret_q       <= ret_d;
            ld_cnt_q    <= ld_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            tmo_q       <= tmo_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign pif.IFID_clear  = ctrl.ifid_clear;
    assign pif.IDEX_clear  = ctrl.idex_clear;
    assign pif.EXMEM_clear = ctrl.exmem_clear;
    assign pif.IFID_wren   = ctrl.ifid_wren;
    assign pif.IDEX_wren   = ctrl.idex_wren;
    assign pif.EXMEM_wren  = ctrl.exmem_wren;
    assign pif.pc_wren     = ctrl.pc_wren;
    assign o_mem_timeout   = tmo_q;
    assign o_stall_cnt     = stall_cnt_q;
    assign o_flush_cnt     = flush_cnt_q;
endmodule
